// File: rtl/load_use_scoreboard.sv
// load_use_scoreboard: load-use hazard detector for the in-order pipeline.
// A MEM_LAT-deep shift register remembers the destination of every in-flight
// load. An ID-stage instruction that reads one of those registers is held and
// a bubble is sent to EX until the load's data can be forwarded. A memory-busy
// freeze holds everything. A saturating counter tallies hazard-stall cycles.
module load_use_scoreboard #(
    parameter int REG_W   = 5,
    parameter int MEM_LAT = 1,
    parameter int CNT_W   = 16
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               IssueValid_ID,
    input  logic               IsLoad_ID,
    input  logic [REG_W-1:0]   Rd_ID,
    input  logic [REG_W-1:0]   Rs_ID,
    input  logic [REG_W-1:0]   Rt_ID,
    input  logic               UsesRs_ID,
    input  logic               UsesRt_ID,
    input  logic               MemBusy,
    output logic               Stall,
    output logic               Bubble_EX,
    output logic [MEM_LAT-1:0] Pending,
    output logic [CNT_W-1:0]   StallCount
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Slot 0 is the youngest load; slot MEM_LAT-1 is the oldest still pending.
    logic [MEM_LAT-1:0] slot_valid;
    logic [REG_W-1:0]   slot_dest [MEM_LAT];
    logic [CNT_W-1:0]   stall_count;

    logic               any_match;
    logic               hazard;
    logic               issue;
    logic               push_valid;
    logic [REG_W-1:0]   push_dest;

    // Compare both ID sources against every live slot; register 0 never matches.
    always_comb begin
        // NOTE: the flag gets its default before the loop so no latch is inferred.
        any_match = 1'b0;
        for (int k = 0; k < MEM_LAT; k++) begin
            if (slot_valid[k] && (slot_dest[k] != '0) &&
                ((UsesRs_ID && (Rs_ID == slot_dest[k])) ||
                 (UsesRt_ID && (Rt_ID == slot_dest[k])))) begin
                any_match = 1'b1;
            end
        end
    end

    // Decode stall, bubble and issue, and form the entry entering slot 0.
    always_comb begin
        hazard     = IssueValid_ID & any_match;
        Stall      = ~Reset | MemBusy | hazard;
        Bubble_EX  = Reset & ~MemBusy & hazard;
        issue      = Reset & ~MemBusy & ~hazard & IssueValid_ID;
        push_valid = issue & IsLoad_ID & (Rd_ID != '0);
        push_dest  = push_valid ? Rd_ID : '0;
    end

    // Scoreboard shift: reset clears, MemBusy freezes, otherwise age by one slot.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            // NOTE: dest fields are cleared with the valid bits so the slot array
            // is fully defined after reset, not just the bits that gate hazards.
            slot_valid <= '0;
            for (int k = 0; k < MEM_LAT; k++) begin
                slot_dest[k] <= '0;
            end
        end else if (!MemBusy) begin
            // NOTE: non-blocking assignments make every slot take its neighbour's
            // pre-edge value, giving a true one-step shift.
            for (int k = MEM_LAT - 1; k >= 1; k--) begin
                slot_valid[k] <= slot_valid[k-1];
                slot_dest[k]  <= slot_dest[k-1];
            end
            slot_valid[0] <= push_valid;
            slot_dest[0]  <= push_dest;
        end
    end

    // Saturating count of hazard-stall cycles, frozen while memory is busy.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            stall_count <= '0;
        end else if (!MemBusy && hazard && (stall_count != CNT_MAX)) begin
            stall_count <= stall_count + CNT_ONE;
        end
    end

    assign Pending    = slot_valid;
    assign StallCount = stall_count;

endmodule

// File: tb/tb_load_use_scoreboard.sv
// Testbench for load_use_scoreboard. Three instances (MEM_LAT 1/3/2, the last
// with a 4-bit counter) share one input stream. Directed scenarios check the
// targeted instance against hand-derived values; a random phase checks all
// instances against a history-based reference model.
module tb_load_use_scoreboard;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        IssueValid_ID = 1'b0;
    logic        IsLoad_ID = 1'b0;
    logic [4:0]  Rd_ID = '0;
    logic [4:0]  Rs_ID = '0;
    logic [4:0]  Rt_ID = '0;
    logic        UsesRs_ID = 1'b0;
    logic        UsesRt_ID = 1'b0;
    logic        MemBusy = 1'b0;

    logic        stall0, stall1, stall2;
    logic        bub0, bub1, bub2;
    logic [0:0]  pend0;
    logic [2:0]  pend1;
    logic [1:0]  pend2;
    logic [15:0] cnt0, cnt1;
    logic [3:0]  cnt2;

    load_use_scoreboard #(.REG_W(5), .MEM_LAT(1), .CNT_W(16)) u_lat1 (
        .Clk(Clk), .Reset(Reset), .IssueValid_ID(IssueValid_ID), .IsLoad_ID(IsLoad_ID),
        .Rd_ID(Rd_ID), .Rs_ID(Rs_ID), .Rt_ID(Rt_ID), .UsesRs_ID(UsesRs_ID),
        .UsesRt_ID(UsesRt_ID), .MemBusy(MemBusy), .Stall(stall0), .Bubble_EX(bub0),
        .Pending(pend0), .StallCount(cnt0)
    );

    load_use_scoreboard #(.REG_W(5), .MEM_LAT(3), .CNT_W(16)) u_lat3 (
        .Clk(Clk), .Reset(Reset), .IssueValid_ID(IssueValid_ID), .IsLoad_ID(IsLoad_ID),
        .Rd_ID(Rd_ID), .Rs_ID(Rs_ID), .Rt_ID(Rt_ID), .UsesRs_ID(UsesRs_ID),
        .UsesRt_ID(UsesRt_ID), .MemBusy(MemBusy), .Stall(stall1), .Bubble_EX(bub1),
        .Pending(pend1), .StallCount(cnt1)
    );

    load_use_scoreboard #(.REG_W(5), .MEM_LAT(2), .CNT_W(4)) u_lat2 (
        .Clk(Clk), .Reset(Reset), .IssueValid_ID(IssueValid_ID), .IsLoad_ID(IsLoad_ID),
        .Rd_ID(Rd_ID), .Rs_ID(Rs_ID), .Rt_ID(Rt_ID), .UsesRs_ID(UsesRs_ID),
        .UsesRt_ID(UsesRt_ID), .MemBusy(MemBusy), .Stall(stall2), .Bubble_EX(bub2),
        .Pending(pend2), .StallCount(cnt2)
    );

    always #5 Clk = ~Clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: a log of which load destination entered the pipe at each
    // advancing edge. A load logged at advance index i is pending in slot
    // (adv - i) while that age is below the configured latency.
    int          lat [3]  = '{1, 3, 2};
    int          cmax [3] = '{65535, 65535, 15};
    int          hist [3][0:2047];
    int          adv = 0;
    int          valid_from = 0;
    int          mcnt [3] = '{0, 0, 0};
    bit          mhaz [3];
    logic        exp_stall [3];
    logic        exp_bub [3];
    logic [7:0]  exp_pend [3];
    logic [15:0] exp_cnt [3];

    function automatic logic get_stall(int m);
        case (m)
            0:       return stall0;
            1:       return stall1;
            default: return stall2;
        endcase
    endfunction

    function automatic logic get_bub(int m);
        case (m)
            0:       return bub0;
            1:       return bub1;
            default: return bub2;
        endcase
    endfunction

    function automatic logic [7:0] get_pend(int m);
        case (m)
            0:       return {7'b0, pend0};
            1:       return {5'b0, pend1};
            default: return {6'b0, pend2};
        endcase
    endfunction

    function automatic logic [15:0] get_cnt(int m);
        case (m)
            0:       return cnt0;
            1:       return cnt1;
            default: return {12'b0, cnt2};
        endcase
    endfunction

    task automatic model_eval();
        for (int m = 0; m < 3; m++) begin
            logic [7:0] p;
            bit         h;
            p = '0;
            h = 1'b0;
            for (int age = 0; age < lat[m]; age++) begin
                int idx;
                idx = adv - age;
                if (idx > valid_from && hist[m][idx] != 0) begin
                    p[age] = 1'b1;
                    if ((UsesRs_ID && int'(Rs_ID) == hist[m][idx]) ||
                        (UsesRt_ID && int'(Rt_ID) == hist[m][idx]))
                        h = 1'b1;
                end
            end
            mhaz[m]      = IssueValid_ID && h;
            exp_stall[m] = !Reset || MemBusy || mhaz[m];
            exp_bub[m]   = Reset && !MemBusy && mhaz[m];
            exp_pend[m]  = p;
            exp_cnt[m]   = 16'(mcnt[m]);
        end
    endtask

    task automatic model_edge();
        if (!Reset) begin
            valid_from = adv;
            for (int m = 0; m < 3; m++) mcnt[m] = 0;
        end else if (!MemBusy) begin
            adv++;
            for (int m = 0; m < 3; m++) begin
                if (IssueValid_ID && !mhaz[m] && IsLoad_ID && Rd_ID != 0)
                    hist[m][adv] = int'(Rd_ID);
                else
                    hist[m][adv] = 0;
                if (mhaz[m] && mcnt[m] < cmax[m]) mcnt[m]++;
            end
        end
    endtask

    // Drive one cycle's inputs after the falling edge and evaluate the model.
    task automatic apply(input logic rst, input logic busy, input logic iv, input logic ld,
                         input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt,
                         input logic urs, input logic urt);
        @(negedge Clk);
        Reset = rst; MemBusy = busy; IssueValid_ID = iv; IsLoad_ID = ld;
        Rd_ID = rd; Rs_ID = rs; Rt_ID = rt; UsesRs_ID = urs; UsesRt_ID = urt;
        #1;
        model_eval();
    endtask

    task automatic tick();
        @(posedge Clk);
        model_edge();
    endtask

    task automatic do_reset();
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_reset();
        for (int c = 0; c < 3; c++) begin
            apply(0, 1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom), 5'($urandom),
                  5'($urandom), 1'($urandom), 1'($urandom));
            n_cmp++;
            if ({stall0, stall1, stall2, bub0, bub1, bub2, pend0, pend1, pend2, cnt0, cnt1, cnt2}
                !== {3'b111, 3'b000, 6'b0, 36'b0}) begin
                n_bad++;
                $display("FAIL reset_c%0d: got stall=%b%b%b bub=%b%b%b pend=%b/%b/%b cnt=%0d/%0d/%0d want stall=111 bub=000 pend=0 cnt=0",
                         c, stall0, stall1, stall2, bub0, bub1, bub2, pend0, pend1, pend2,
                         cnt0, cnt1, cnt2);
            end
            tick();
        end
    endtask

    task automatic test_classic_lat1();
        do_reset();
        apply(1, 0, 1, 1, 8, 0, 0, 0, 0);
        n_cmp++;
        if ({stall0, bub0, pend0} !== 3'b000) begin
            n_bad++; $display("FAIL classic_lw: got %b want 000", {stall0, bub0, pend0});
        end
        tick();
        apply(1, 0, 1, 0, 9, 8, 0, 1, 0);
        n_cmp++;
        if ({stall0, bub0, pend0} !== 3'b111) begin
            n_bad++; $display("FAIL classic_stall: got %b want 111", {stall0, bub0, pend0});
        end
        tick();
        apply(1, 0, 1, 0, 9, 8, 0, 1, 0);
        n_cmp++;
        if ({stall0, bub0, pend0, cnt0} !== {3'b000, 16'd1}) begin
            n_bad++; $display("FAIL classic_issue: got s/b/p=%b cnt=%0d want 000 cnt=1",
                              {stall0, bub0, pend0}, cnt0);
        end
        tick();
    endtask

    task automatic test_lat3_distance2();
        logic [4:0] want [5] = '{5'b00000, 5'b00001, 5'b11010, 5'b11100, 5'b00000};
        do_reset();
        for (int c = 0; c < 5; c++) begin
            if (c == 0)      apply(1, 0, 1, 1, 5, 0, 0, 0, 0);
            else if (c == 1) apply(1, 0, 1, 0, 7, 1, 2, 1, 1);
            else             apply(1, 0, 1, 0, 9, 0, 5, 0, 1);
            n_cmp++;
            if ({stall1, bub1, pend1} !== want[c]) begin
                n_bad++; $display("FAIL lat3_c%0d: got %b want %b", c, {stall1, bub1, pend1}, want[c]);
            end
            tick();
        end
        n_cmp++;
        if (cnt1 !== 16'd2) begin
            n_bad++; $display("FAIL lat3_count: got %0d want 2", cnt1);
        end
    endtask

    task automatic test_nonhazard();
        do_reset();
        apply(1, 0, 1, 1, 0, 0, 0, 0, 0);
        tick();
        apply(1, 0, 1, 0, 4, 0, 0, 1, 1);
        n_cmp++;
        if ({stall0, stall1, stall2} !== 3'b000) begin
            n_bad++; $display("FAIL nonhaz_r0: got %b want 000", {stall0, stall1, stall2});
        end
        tick();
        apply(1, 0, 1, 1, 9, 0, 0, 0, 0);
        tick();
        apply(1, 0, 1, 0, 4, 9, 3, 0, 1);
        n_cmp++;
        if ({stall0, stall1, stall2} !== 3'b000) begin
            n_bad++; $display("FAIL nonhaz_unused: got %b want 000", {stall0, stall1, stall2});
        end
        tick();
        apply(1, 0, 0, 0, 0, 0, 0, 0, 0);
        n_cmp++;
        if ({cnt0, cnt1, cnt2} !== 36'd0) begin
            n_bad++; $display("FAIL nonhaz_count: got %0d/%0d/%0d want 0", cnt0, cnt1, cnt2);
        end
        tick();
    endtask

    task automatic test_membusy_lat2();
        do_reset();
        apply(1, 0, 1, 1, 12, 0, 0, 0, 0);
        tick();
        apply(1, 0, 1, 0, 4, 12, 0, 1, 0);
        n_cmp++;
        if ({stall2, bub2, pend2} !== 4'b1101) begin
            n_bad++; $display("FAIL busy_pre: got %b want 1101", {stall2, bub2, pend2});
        end
        tick();
        for (int c = 0; c < 4; c++) begin
            apply(1, 1, 1, 0, 4, 12, 0, 1, 0);
            n_cmp++;
            if ({stall2, bub2, pend2, cnt2} !== {4'b1010, 4'd1}) begin
                n_bad++; $display("FAIL busy_hold_c%0d: got s/b/p=%b cnt=%0d want 1010 cnt=1",
                                  c, {stall2, bub2, pend2}, cnt2);
            end
            tick();
        end
        apply(1, 0, 1, 0, 4, 12, 0, 1, 0);
        n_cmp++;
        if ({stall2, bub2, pend2, cnt2} !== {4'b1110, 4'd1}) begin
            n_bad++; $display("FAIL busy_resume: got s/b/p=%b cnt=%0d want 1110 cnt=1",
                              {stall2, bub2, pend2}, cnt2);
        end
        tick();
        apply(1, 0, 1, 0, 4, 12, 0, 1, 0);
        n_cmp++;
        if ({stall2, bub2, pend2, cnt2} !== {4'b0000, 4'd2}) begin
            n_bad++; $display("FAIL busy_done: got s/b/p=%b cnt=%0d want 0000 cnt=2",
                              {stall2, bub2, pend2}, cnt2);
        end
        tick();
    endtask

    task automatic test_saturation_and_reset();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            apply(1, 0, 1, 1, 5'(10 + i), 0, 0, 0, 0);
            tick();
            for (int c = 0; c < 3; c++) begin
                apply(1, 0, 1, 0, 2, 5'(10 + i), 0, 1, 0);
                tick();
            end
        end
        apply(1, 0, 0, 0, 0, 0, 0, 0, 0);
        n_cmp++;
        if ({cnt0, cnt1, cnt2} !== {16'd10, 16'd30, 4'd15}) begin
            n_bad++; $display("FAIL sat_count: got %0d/%0d/%0d want 10/30/15", cnt0, cnt1, cnt2);
        end
        tick();
        apply(1, 0, 1, 1, 3, 0, 0, 0, 0);
        tick();
        apply(1, 0, 0, 0, 0, 0, 0, 0, 0);
        n_cmp++;
        if (pend2 !== 2'b01) begin
            n_bad++; $display("FAIL midrst_pre: got pend=%b want 01", pend2);
        end
        apply(0, 0, 1, 0, 2, 3, 0, 1, 0);
        tick();
        apply(1, 0, 1, 0, 2, 3, 0, 1, 0);
        n_cmp++;
        if ({stall2, bub2, pend2, cnt2} !== 8'd0) begin
            n_bad++; $display("FAIL midrst_post: got s/b/p=%b cnt=%0d want 0000 cnt=0",
                              {stall2, bub2, pend2}, cnt2);
        end
        tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            apply(1'($urandom_range(0, 49) != 0), 1'($urandom_range(0, 9) == 0),
                  1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 2) == 0),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  1'($urandom), 1'($urandom));
            for (int m = 0; m < 3; m++) begin
                n_cmp++;
                if ({get_stall(m), get_bub(m), get_pend(m), get_cnt(m)} !==
                    {exp_stall[m], exp_bub[m], exp_pend[m], exp_cnt[m]}) begin
                    n_bad++;
                    $display("FAIL random_c%0d_lat%0d: got s=%b b=%b p=%b cnt=%0d want s=%b b=%b p=%b cnt=%0d",
                             c, lat[m], get_stall(m), get_bub(m), get_pend(m), get_cnt(m),
                             exp_stall[m], exp_bub[m], exp_pend[m], exp_cnt[m]);
                end
            end
            tick();
        end
    endtask

    initial begin
        for (int m = 0; m < 3; m++)
            for (int i = 0; i < 2048; i++) hist[m][i] = 0;
        test_reset();
        test_classic_lat1();
        test_lat3_distance2();
        test_nonhazard();
        test_membusy_lat2();
        test_saturation_and_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/load_use_scoreboard.md
# load_use_scoreboard

Parametrised load-use hazard detector for the in-order MIPS pipeline, sitting between the ID stage and the ID/EX pipeline register. It tracks every in-flight load in a MEM_LAT-deep shift-register scoreboard and stalls any ID-stage instruction whose source register matches a pending load destination. The stall length therefore follows the configured memory latency rather than a fixed one cycle. It also freezes on a memory-busy signal, inserts bubbles into EX, and keeps a saturating hazard-stall counter for performance debug.

## Interface
- REG_W, 5: register address width.
- MEM_LAT, 1: load-to-use distance in cycles, legal range 1..8. This is the number of scoreboard slots.
- CNT_W, 16: width of the stall counter.

- Clk  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-low.
- IssueValid_ID  in  1  ID holds a valid instruction.
- IsLoad_ID  in  1  the ID instruction is a load.
- Rd_ID  in  REG_W  destination register of the ID instruction.
- Rs_ID, Rt_ID  in  REG_W  source registers of the ID instruction.
- UsesRs_ID, UsesRt_ID  in  1  the matching source is actually read.
- MemBusy  in  1  data memory not ready; freezes the whole pipeline.
- Stall  out  1  hold PC and IF/ID.
- Bubble_EX  out  1  load a NOP into ID/EX this cycle.
- Pending  out  MEM_LAT  valid bits of the scoreboard slots, slot 0 is the LSB.
- StallCount  out  CNT_W  number of hazard-stall cycles, saturating.

## Operation
- **Scoreboard.** The scoreboard is slots 0..MEM_LAT-1. Each slot holds {valid, dest[REG_W-1:0]}.
- **Match.** Slot k matches when valid=1, dest≠0, and either of these holds:
  - UsesRs_ID=1 and Rs_ID=dest
  - UsesRt_ID=1 and Rt_ID=dest
- **Hazard.** hazard = IssueValid_ID & (any slot matches). Register 0 never causes a hazard.
- **Outputs (combinational).**
  - Stall = ~Reset | MemBusy | hazard.
  - Bubble_EX = Reset & ~MemBusy & hazard.
- **Issue.** issue = Reset & ~MemBusy & ~hazard & IssueValid_ID.
- **Push.** On issue with IsLoad_ID=1 and Rd_ID≠0, the entry shifted into slot 0 is {1, Rd_ID}. Otherwise the shifted-in entry is {0, 0}; stalled cycles shift in bubbles.
- **Clock-edge priority.**
  1. Reset=0: clear all slots and StallCount to 0.
  2. Else MemBusy=1: hold all slots and StallCount.
  3. Else: shift, so slot k+1 takes slot k, slot 0 takes the new entry, and slot MEM_LAT-1 is discarded.
- **Counter.** StallCount increments on every edge where Reset=1, MemBusy=0 and hazard=1. It holds at 2^CNT_W-1.
- **Issue-and-match cycle.** A load in ID that itself matches a pending slot stalls and is not pushed until it issues.
- **Pending** reflects the registered slot valid bits directly.

## Timing
- **Reset values.** While Reset=0: Stall=1, Bubble_EX=0, Pending=0, StallCount=0. After the first edge with Reset=1, Stall depends only on MemBusy and hazard.
- **Load-use latency.**
  - A load issues at cycle t.
  - A dependent instruction in ID at t+d, for 1≤d≤MEM_LAT, sees Stall=1 and Bubble_EX=1 for MEM_LAT-d+1 cycles.
  - The dependent instruction issues at cycle MEM_LAT+1 after the load.
  - For d>MEM_LAT there is no stall.
- **MemBusy.** A MemBusy cycle neither advances the scoreboard nor counts. Hazard stalls resume where they left off after MemBusy drops.
- **Reset mid-stall.** Reset asserted mid-stall discards all pending entries. The first cycle after release has no hazard.
- **No internal delay.** Outputs have zero combinational-to-register delay inside the block. The pipeline samples Stall and Bubble_EX at the same edge the scoreboard updates.

## Test plan
- **Reset.** Hold Reset=0 for 3 cycles with arbitrary inputs. Required: Stall=1, Bubble_EX=0, Pending=0, StallCount=0.
- **Classic load-use, MEM_LAT=1.** Issue `lw $8`, then `add` with Rs=8 at the next cycle. Required: exactly 1 cycle of Stall=1 and Bubble_EX=1; StallCount=1; add issues the cycle after.
- **MEM_LAT=3, distance 2.** Issue `lw $5`, one unrelated instruction, then a consumer with Rt=5 and UsesRt=1. Required: 2 stall cycles; Pending goes 001, 010, 100, 000 in the cycles before the consumer issues, with bubble entries shifting in while stalled.
- **Non-hazards.** Cover a load to $0 followed by a consumer of $0, and a consumer with Rs match but UsesRs=0. Required: Stall=0 and StallCount unchanged in both cases.
- **MemBusy freeze.** With MEM_LAT=2, stall on a pending load, then raise MemBusy for 4 cycles mid-stall. Required: Stall=1, Bubble_EX=0, Pending frozen, StallCount frozen; the stall completes after MemBusy drops.
- **Counter saturation and reset mid-operation.** With CNT_W=4, cause 20 hazard cycles; StallCount must hold at 15. Then drive Reset=0 for one edge with Pending≠0. Required: Pending=0 and StallCount=0 on the next cycle.
